// File: rtl/parity_pkg.sv
// Shared definitions for the XOR-fold parity generator/checker pair.
// Holds the default widths, the syndrome type and a reference fold function.
package parity_pkg;

  localparam int DEFAULT_DATA_WIDTH = 256;
  localparam int DEFAULT_PAR_WIDTH  = 32;
  localparam int DEFAULT_WORDS      = DEFAULT_DATA_WIDTH / DEFAULT_PAR_WIDTH;

  typedef logic [DEFAULT_PAR_WIDTH-1:0] syndrome_t;

  // Function form of the fold for default-width users (e.g. generator side).
  function automatic syndrome_t fold(input logic [DEFAULT_DATA_WIDTH-1:0] data);
    syndrome_t acc;
    acc = '0;
    for (int k = 0; k < DEFAULT_WORDS; k++) begin
      acc ^= data[k*DEFAULT_PAR_WIDTH +: DEFAULT_PAR_WIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/parity_fold.sv
// Combinational XOR fold of a DATA_WIDTH beat down to PAR_WIDTH bits.
// Shared between the parity generator and the parity checker.
module parity_fold #(
  parameter int DATA_WIDTH = 256,
  parameter int PAR_WIDTH  = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [PAR_WIDTH-1:0]  fold
);

  localparam int NUM_WORDS = DATA_WIDTH / PAR_WIDTH;

  logic [PAR_WIDTH-1:0] words [NUM_WORDS];

  generate
    if ((DATA_WIDTH % PAR_WIDTH) != 0) begin : g_width_check
      $error("parity_fold: DATA_WIDTH must be a multiple of PAR_WIDTH");
    end
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      assign words[gi] = data[gi*PAR_WIDTH +: PAR_WIDTH];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      fold ^= words[k];
    end
  end

endmodule

// File: rtl/parity_checker.sv
// Two-stage valid/ready parity checker: recompute fold, compare, flag, count.
// Optional build macro PARITY_CHECKER_DROP_EN discards beats with a nonzero syndrome.
module parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PAR_WIDTH  = DEFAULT_PAR_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr_stats,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [PAR_WIDTH-1:0]  in_parity,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [PAR_WIDTH-1:0]  out_syndrome,
  output logic                  out_error,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_sticky
);

  // run_reg keeps in_ready low while reset is held without using rst combinationally.
  logic                  run_reg;
  logic                  s1_valid_reg;
  logic [DATA_WIDTH-1:0] s1_data_reg;
  logic [PAR_WIDTH-1:0]  s1_fold_reg;
  logic [PAR_WIDTH-1:0]  s1_parity_reg;
  logic                  s2_valid_reg;
  logic                  s2_taken_reg;
  logic [DATA_WIDTH-1:0] s2_data_reg;
  logic [PAR_WIDTH-1:0]  s2_syn_reg;
  logic                  s2_err_reg;
  logic [CNT_WIDTH-1:0]  err_count_reg;
  logic [CNT_WIDTH-1:0]  err_count_next;
  logic                  err_sticky_reg;
  logic                  err_sticky_next;

  logic [PAR_WIDTH-1:0]  in_fold;
  logic [PAR_WIDTH-1:0]  s1_syn;
  logic                  s1_err;
  logic                  s1_drop;
  logic                  s2_load;
  logic                  adv1;
  logic                  adv2;
  logic                  count_now;

  parity_fold #(
    .DATA_WIDTH (DATA_WIDTH),
    .PAR_WIDTH  (PAR_WIDTH)
  ) u_fold (
    .data (in_data),
    .fold (in_fold)
  );

  assign s1_syn = s1_fold_reg ^ s1_parity_reg;
  assign s1_err = |s1_syn;

`ifdef PARITY_CHECKER_DROP_EN
  assign s1_drop = s1_valid_reg & s1_err;
`else
  assign s1_drop = 1'b0;
`endif

  // s2_taken_reg remembers a handshake completed while enable was low so the
  // beat retires (instead of being offered twice) when enable returns.
  assign adv2      = enable & (~s2_valid_reg | out_ready | s2_taken_reg);
  assign adv1      = enable & run_reg & (~s1_valid_reg | adv2 | s1_drop);
  assign s2_load   = s1_valid_reg & ~s1_drop;
  assign count_now = adv1 & s1_valid_reg & s1_err;

  assign in_ready     = adv1;
  assign out_valid    = s2_valid_reg;
  assign out_data     = s2_data_reg;
  assign out_syndrome = s2_syn_reg;
  assign out_error    = s2_err_reg;
  assign err_count    = err_count_reg;
  assign err_sticky   = err_sticky_reg;

  always_comb begin
    err_count_next  = err_count_reg;
    err_sticky_next = err_sticky_reg;
    if (clr_stats) begin
      err_count_next  = '0;
      err_sticky_next = 1'b0;
    end else if (count_now) begin
      err_sticky_next = 1'b1;
      if (!(&err_count_reg)) begin
        err_count_next = err_count_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg        <= 1'b0;
      s1_valid_reg   <= 1'b0;
      s2_valid_reg   <= 1'b0;
      s2_taken_reg   <= 1'b0;
      s2_data_reg    <= '0;
      s2_syn_reg     <= '0;
      s2_err_reg     <= 1'b0;
      err_count_reg  <= '0;
      err_sticky_reg <= 1'b0;
    end else begin
      run_reg        <= 1'b1;
      err_count_reg  <= err_count_next;
      err_sticky_reg <= err_sticky_next;
      if (adv1) begin
        s1_valid_reg <= in_valid;
      end
      if (adv2) begin
        s2_valid_reg <= s2_load;
        if (s2_load) begin
          s2_data_reg <= s1_data_reg;
          s2_syn_reg  <= s1_syn;
          s2_err_reg  <= s1_err;
        end
      end
      if (enable) begin
        s2_taken_reg <= 1'b0;
      end else if (s2_valid_reg && out_ready) begin
        s2_taken_reg <= 1'b1;
      end
    end
  end

  // Stage-1 payload is qualified by s1_valid_reg, so it needs no reset.
  always_ff @(posedge clk) begin
    if (adv1) begin
      s1_data_reg   <= in_data;
      s1_fold_reg   <= in_fold;
      s1_parity_reg <= in_parity;
    end
  end

endmodule
